rv0_ahb_arb: RTL
================

// Module: rv0_ahb_arb
// PURPOSE
//  Two-requester arbiter and AHB-Lite transfer sequencer for the rv0 core.
//  Shares one ahb_if requester port between instruction fetch (IF) and the load/store unit (LS).
//  Non-pipelined: one outstanding transfer at a time. Round-robin on contention.
//  Each transfer is sequenced as an address phase then a data phase, and ends with a response pulse to its owner.
// PARAMETERS
//  ADDR_WIDTH  32  AHB address width and request address width
//  DATA_WIDTH  32  AHB data width; STRB_WIDTH = DATA_WIDTH/8
// PORTS
//  clk        in   1     core clock; all state changes on rising edge
//  rst        in   1     synchronous, active-high reset
//  if_req     in   1     IF request; holds stable until if_gnt
//  if_addr    in   AW    IF fetch address; always a word read
//  if_gnt     out  1     IF request accepted (1-cycle pulse)
//  if_rvld    out  1     IF response valid (1-cycle pulse)
//  if_rdata   out  DW    IF read data, valid with if_rvld
//  if_err     out  1     IF bus error, valid with if_rvld
//  ls_req     in   1     LS request; all ls_* inputs hold stable until ls_gnt
//  ls_we      in   1     1 = write, 0 = read
//  ls_addr    in   AW    LS address
//  ls_size    in   3     ahb_uvc_hsize_e; BYTE/HALF/WORD legal
//  ls_wdata   in   DW    LS write data
//  ls_strb    in   SW    LS write strobes
//  ls_gnt     out  1     LS request accepted (1-cycle pulse)
//  ls_rvld    out  1     LS response valid (1-cycle pulse)
//  ls_rdata   out  DW    LS read data
//  ls_err     out  1     LS bus or misalignment error
//  haddr/htrans/hsize/hwrite/hwdata/hwstrb/hsel/hprot  out  ahb_if requester outputs
//  hrdata/hreadyout/hresp  in   ahb_if requester inputs
//  Other ahb_if outputs are tied off in the enclosing core.
// BEHAVIOUR
//  Reset values
//   - FSM goes to IDLE.
//   - All outputs are 0, including htrans=HTRANS_IDLE and hsel=0.
//   - rr pointer selects LS first.
//  FSM states: IDLE, ADDR, DATA, RESP
//   - IDLE: if any req is pending, arbitrate.
//     Pulse the winner's gnt combinationally in this cycle and latch its request.
//     Go to ADDR; if it is an LS misaligned request, go to RESP instead.
//   - ADDR (1 cycle): htrans=HTRANS_NONSEQ, hsel=1; haddr/hsize/hwrite/hprot come from the latch.
//     Always go to DATA.
//   - DATA: htrans=HTRANS_IDLE, hsel=0; hwdata/hwstrb come from the latch.
//     Wait for hreadyout=1. Then capture hrdata and hresp, and go to RESP.
//   - RESP (1 cycle): owner's rvld=1, with rdata and err registered; go to IDLE.
//  Arbitration and latency
//   - If only one requester is pending, it wins.
//   - If both are pending, the winner is the one not granted last; the pointer updates on every gnt.
//   - No new grant is issued while outside IDLE. if_gnt and ls_gnt are never high in the same cycle.
//   - Minimum latency: req seen in cycle N -> gnt at N -> rvld at N+3.
//     Each DATA wait state adds one cycle.
//  Per-requester encoding
//   - IF: hsize=HSIZE_WORD, hwrite=0, hwstrb=0, hprot=4'b0010.
//   - LS: hsize=ls_size, hwrite=ls_we, hprot=4'b0011.
//   - Reads drive hwstrb=0.
//  Misalignment (LS only)
//   - Applies when HALF has addr[0]!=0 or WORD has addr[1:0]!=0.
//   - Also applies when ls_size > HSIZE_WORD.
//   - The request is granted with no AHB transfer, and ls_rvld+ls_err follow at N+1.
//   - IF addresses are used as given.
//  Error and data handling
//   - AHB ERROR response: the transfer completes on the hreadyout=1 cycle with err=1.
//   - Read data is passed through unchanged on error; it is not blocked.
//   - rdata is held between responses; it is don't-care unless rvld=1.
//  Reset mid-transfer: return to IDLE immediately. No rvld is issued for the aborted transfer.
// TESTING
//  - LS read only, 0x100, WORD, hreadyout=1 -> ls_gnt@0; NONSEQ@1 haddr=0x100; ls_rvld@3, rdata=hrdata.
//  - IF+LS both reqs asserted after reset -> LS granted first, then IF; repeat both -> alternates LS,IF,LS,IF.
//  - LS write 0x203, BYTE, strb 4'b1000, 2 wait states -> hwdata held 3 cycles in DATA, ls_rvld@5.
//  - LS HALF at 0x101 -> ls_gnt, ls_rvld+ls_err next cycle; htrans stays IDLE throughout.
//  - IF read, hresp=1 on final cycle -> if_rvld with if_err=1; next req served normally.
//  - rst=1 during DATA -> next cycle IDLE, all outputs 0, no rvld; pending req granted after rst drops.

Source files
------------

// File: rtl/rv0_ahb_arb_if.sv
// Requester-side bundle for the rv0 fetch/load-store arbiter and its AHB-Lite port.
// No latency of its own; pure wiring between the arbiter and its neighbours.
// Flow control is req/gnt per requester and hreadyout wait states on the bus.
interface rv0_ahb_arb_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    // Instruction fetch requester
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvld;
    logic [DATA_WIDTH-1:0] if_rdata;
    logic                  if_err;

    // Load/store requester
    logic                  ls_req;
    logic                  ls_we;
    logic [ADDR_WIDTH-1:0] ls_addr;
    logic [2:0]            ls_size;
    logic [DATA_WIDTH-1:0] ls_wdata;
    logic [STRB_WIDTH-1:0] ls_strb;
    logic                  ls_gnt;
    logic                  ls_rvld;
    logic [DATA_WIDTH-1:0] ls_rdata;
    logic                  ls_err;

    // AHB-Lite requester port
    logic [ADDR_WIDTH-1:0] haddr;
    logic [1:0]            htrans;
    logic [2:0]            hsize;
    logic                  hwrite;
    logic [DATA_WIDTH-1:0] hwdata;
    logic [STRB_WIDTH-1:0] hwstrb;
    logic                  hsel;
    logic [3:0]            hprot;
    logic [DATA_WIDTH-1:0] hrdata;
    logic                  hreadyout;
    logic                  hresp;

    // Arbiter view: drives grants, responses and the AHB address/data phase.
    modport master (
        input  if_req, if_addr,
        output if_gnt, if_rvld, if_rdata, if_err,
        input  ls_req, ls_we, ls_addr, ls_size, ls_wdata, ls_strb,
        output ls_gnt, ls_rvld, ls_rdata, ls_err,
        output haddr, htrans, hsize, hwrite, hwdata, hwstrb, hsel, hprot,
        input  hrdata, hreadyout, hresp
    );

    // Environment view: requesters and the AHB completer.
    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_rvld, if_rdata, if_err,
        output ls_req, ls_we, ls_addr, ls_size, ls_wdata, ls_strb,
        input  ls_gnt, ls_rvld, ls_rdata, ls_err,
        input  haddr, htrans, hsize, hwrite, hwdata, hwstrb, hsel, hprot,
        output hrdata, hreadyout, hresp
    );
endinterface

// File: rtl/rv0_ahb_arb.sv
// Round-robin arbiter between IF and LS sharing one non-pipelined AHB-Lite requester port.
// Latency: gnt same cycle as req in IDLE, rvld 3 cycles later (+1 per wait state); misaligned LS: rvld 1 cycle after gnt.
// Backpressure: requests wait (req held) while a transfer is in flight; hreadyout=0 stretches the data phase.
module rv0_ahb_arb #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    rv0_ahb_arb_if.master bus
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic [3:0] HPROT_IF = 4'b0010;
    localparam logic [3:0] HPROT_LS = 4'b0011;

    logic [1:0]            state;
    logic [1:0]            state_nxt;

    // 1 when IF held the most recent grant, so LS wins the next tie.
    logic                  last_if;
    // Owner of the transfer currently being sequenced.
    logic                  own_ls;

    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [2:0]            lat_size;
    logic                  lat_we;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic [STRB_WIDTH-1:0] lat_strb;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  ls_misaligned;
    logic                  pick_ls;
    logic                  pick_if;
    logic                  resp_ok;

    // Alignment check on the presented LS request; oversize transfers are rejected too.
    always_comb begin
        case (bus.ls_size)
            HSIZE_BYTE: ls_misaligned = 1'b0;
            HSIZE_HALF: ls_misaligned = bus.ls_addr[0];
            HSIZE_WORD: ls_misaligned = |bus.ls_addr[1:0];
            default:    ls_misaligned = 1'b1;
        endcase
    end

    // Grant selection: only in IDLE and never while reset is asserted; ties go to whoever was not granted last.
    always_comb begin
        pick_ls = 1'b0;
        pick_if = 1'b0;
        if (!rst && (state == ST_IDLE)) begin
            if (bus.ls_req && bus.if_req) begin
                pick_ls = last_if;
                pick_if = !last_if;
            end else begin
                pick_ls = bus.ls_req;
                pick_if = bus.if_req;
            end
        end
    end

    // Transfer sequencing: address phase, data phase with wait states, one-cycle response.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (pick_ls && ls_misaligned) begin
                    state_nxt = ST_RESP;
                end else if (pick_ls || pick_if) begin
                    state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: state_nxt = ST_DATA;
            ST_DATA: begin
                if (bus.hreadyout) begin
                    state_nxt = ST_RESP;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, round-robin pointer, request latch and response capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            last_if   <= 1'b1;
            own_ls    <= 1'b0;
            lat_addr  <= '0;
            lat_size  <= '0;
            lat_we    <= 1'b0;
            lat_wdata <= '0;
            lat_strb  <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (pick_ls) begin
                last_if   <= 1'b0;
                own_ls    <= 1'b1;
                lat_addr  <= bus.ls_addr;
                lat_size  <= bus.ls_size;
                lat_we    <= bus.ls_we;
                lat_wdata <= bus.ls_wdata;
                lat_strb  <= bus.ls_strb;
                // A misaligned request skips the bus and answers with an error directly.
                err_q     <= ls_misaligned;
            end else if (pick_if) begin
                last_if   <= 1'b1;
                own_ls    <= 1'b0;
                lat_addr  <= bus.if_addr;
                lat_size  <= HSIZE_WORD;
                lat_we    <= 1'b0;
                lat_wdata <= '0;
                lat_strb  <= '0;
                err_q     <= 1'b0;
            end
            // Read data is taken even with an error response; the requester decides what to do with it.
            if ((state == ST_DATA) && bus.hreadyout) begin
                rdata_q <= bus.hrdata;
                err_q   <= bus.hresp;
            end
        end
    end

    // AHB outputs: address-phase signals only in ADDR, write data only in DATA, zero otherwise.
    always_comb begin
        bus.haddr  = '0;
        bus.htrans = HTRANS_IDLE;
        bus.hsize  = '0;
        bus.hwrite = 1'b0;
        bus.hprot  = '0;
        bus.hsel   = 1'b0;
        bus.hwdata = '0;
        bus.hwstrb = '0;
        if (state == ST_ADDR) begin
            bus.haddr  = lat_addr;
            bus.htrans = HTRANS_NONSEQ;
            bus.hsize  = lat_size;
            bus.hwrite = lat_we;
            bus.hprot  = own_ls ? HPROT_LS : HPROT_IF;
            bus.hsel   = 1'b1;
        end
        if (state == ST_DATA) begin
            bus.hwdata = lat_wdata;
            bus.hwstrb = lat_we ? lat_strb : '0;
        end
    end

    // Grants and responses back to the requesters; suppressed during reset so aborted transfers stay silent.
    always_comb begin
        resp_ok      = !rst && (state == ST_RESP);
        bus.if_gnt   = pick_if;
        bus.ls_gnt   = pick_ls;
        bus.if_rvld  = resp_ok && !own_ls;
        bus.ls_rvld  = resp_ok && own_ls;
        bus.if_err   = resp_ok && !own_ls && err_q;
        bus.ls_err   = resp_ok && own_ls && err_q;
        bus.if_rdata = rdata_q;
        bus.ls_rdata = rdata_q;
    end
endmodule
